// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with valid/ready handshake; latency STAGES, full throughput.
// Optional rotates (codes 011/100) are built only when SHIFTER_PIPE_ROTATE_EN is defined.
module shifter_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] operantA,
  input  logic [WIDTH-1:0] operantB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             busy
);

  localparam int LW = $clog2(WIDTH);

  logic [LW-1:0]    amt;
  logic             unused_b;
  logic [WIDTH:0]   shl, shr, sar;
  logic [WIDTH-1:0] res;
  logic             cy;
  logic             advance;
`ifdef SHIFTER_PIPE_ROTATE_EN
  logic [WIDTH-1:0] rr, rl;
`endif

  assign amt      = operantB[LW-1:0];
  assign unused_b = ^operantB[WIDTH-1:LW];

  // One extra bit beyond the data catches the last bit shifted out (0 when amt is 0).
  always_comb begin
    shl = {1'b0, operantA} << amt;
    shr = {operantA, 1'b0} >> amt;
    sar = $signed({operantA, 1'b0}) >>> amt;
`ifdef SHIFTER_PIPE_ROTATE_EN
    rr  = (operantA >> amt) | (operantA << (WIDTH - int'(amt)));
    rl  = (operantA << amt) | (operantA >> (WIDTH - int'(amt)));
`endif
    res = '0;
    cy  = 1'b0;
    case (control)
      3'b000: begin res = shl[WIDTH-1:0]; cy = shl[WIDTH]; end
      3'b001: begin res = shr[WIDTH:1];   cy = shr[0];     end
      3'b010: begin res = sar[WIDTH:1];   cy = sar[0];     end
`ifdef SHIFTER_PIPE_ROTATE_EN
      3'b011: begin res = rr; cy = (amt != '0) & rr[WIDTH-1]; end
      3'b100: begin res = rl; cy = (amt != '0) & rl[0];       end
`endif
      default: begin res = '0; cy = 1'b0; end
    endcase
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] cyr;
  logic [WIDTH-1:0]  dat [STAGES];

  assign advance = ~outValid | outReady;
  assign inReady = advance;

  // The whole pipe moves or holds as one, so bubbles keep their slots.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      cyr <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else if (advance) begin
      vld[0] <= inValid;
      cyr[0] <= inValid & cy;
      dat[0] <= inValid ? res : '0;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        cyr[i] <= cyr[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign outValid = vld[STAGES-1];
  assign result   = dat[STAGES-1];
  assign carryOut = cyr[STAGES-1];
  assign busy     = |vld;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe: 32-bit/2-stage main instance plus a 64-bit/6-stage instance.
module tb_shifter_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        inValid, inReady, outValid, outReady, carryOut, busy;
  logic [2:0]  control;
  logic [31:0] operantA, operantB, result;

  logic        v64_in, r64_in, v64_out, c64, b64;
  logic [2:0]  ctl64;
  logic [63:0] a64, bb64, res64;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  shifter_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
    .control(control), .operantA(operantA), .operantB(operantB),
    .outValid(outValid), .outReady(outReady), .result(result),
    .carryOut(carryOut), .busy(busy)
  );

  shifter_pipe #(.WIDTH(64), .STAGES(6)) dut64 (
    .clock(clock), .reset_n(reset_n), .inValid(v64_in), .inReady(r64_in),
    .control(ctl64), .operantA(a64), .operantB(bb64),
    .outValid(v64_out), .outReady(1'b1), .result(res64),
    .carryOut(c64), .busy(b64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_check(input string tag, input logic [2:0] c, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] er, input logic ec);
    inValid  = 1'b1;
    control  = c;
    operantA = a;
    operantB = b;
    step();
    inValid = 1'b0;
    chk({tag, "_lat"}, {63'd0, outValid}, 64'd0);
    step();
    chk({tag, "_valid"}, {63'd0, outValid}, 64'd1);
    chk({tag, "_result"}, {32'd0, result}, {32'd0, er});
    chk({tag, "_carry"}, {63'd0, carryOut}, {63'd0, ec});
  endtask

  logic [31:0] exp_q [5];
  logic        fire_in, fire_out, stalled;
  int          tx, rx, stall_left, cyc;

  initial begin
    reset_n  = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    control  = 3'b000;
    operantA = '0;
    operantB = '0;
    v64_in   = 1'b0;
    ctl64    = 3'b000;
    a64      = '0;
    bb64     = '0;
    #12;
    chk("rst_outValid", {63'd0, outValid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_carry", {63'd0, carryOut}, 64'd0);
    reset_n = 1'b1;
    step();
    chk("rst_inReady", {63'd0, inReady}, 64'd1);

    issue_check("lsl31", 3'b000, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0);
    issue_check("asr4", 3'b010, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    issue_check("lsr4", 3'b001, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
`ifdef SHIFTER_PIPE_ROTATE_EN
    issue_check("ror4", 3'b011, 32'h0000_00F1, 32'd4, 32'h1000_000F, 1'b0);
    issue_check("rol1", 3'b100, 32'h8000_0001, 32'd1, 32'h0000_0003, 1'b1);
`else
    issue_check("ror4", 3'b011, 32'h0000_00F1, 32'd4, 32'h0000_0000, 1'b0);
    issue_check("rol1", 3'b100, 32'h8000_0001, 32'd1, 32'h0000_0000, 1'b0);
`endif
    issue_check("lsl1c", 3'b000, 32'hC000_0000, 32'd1, 32'h8000_0000, 1'b1);
    issue_check("lsr1c", 3'b001, 32'h0000_000F, 32'd1, 32'h0000_0007, 1'b1);
    issue_check("op101", 3'b101, 32'hFFFF_FFFF, 32'd3, 32'h0000_0000, 1'b0);
    issue_check("asr0", 3'b010, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0);
    issue_check("lsl0", 3'b000, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0);
    issue_check("asr31", 3'b010, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);

    // Back-to-back stream with a 3-cycle consumer stall after the first result.
    for (int i = 0; i < 5; i++) exp_q[i] = (i + 1) << i;
    tx = 0; rx = 0; stall_left = 0; stalled = 1'b0;
    step();
    inValid  = 1'b1;
    control  = 3'b000;
    operantA = 32'd1;
    operantB = 32'd0;
    outReady = 1'b1;
    for (cyc = 0; cyc < 40 && rx < 5; cyc++) begin
      @(negedge clock);
      fire_in  = inValid & inReady;
      fire_out = outValid & outReady;
      if (outValid && !outReady) begin
        chk("stall_inReady", {63'd0, inReady}, 64'd0);
        chk("stall_hold", {32'd0, result}, {32'd0, exp_q[rx]});
      end
      if (fire_out) chk($sformatf("stream_res%0d", rx), {32'd0, result}, {32'd0, exp_q[rx]});
      step();
      if (fire_in) tx++;
      if (fire_out) rx++;
      inValid  = (tx < 5);
      operantA = tx + 1;
      operantB = tx;
      if (outValid && !stalled) begin
        stalled    = 1'b1;
        stall_left = 3;
      end
      outReady = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end
    chk("stream_count", 64'(rx), 64'd5);
    inValid  = 1'b0;
    outReady = 1'b1;
    step();
    step();
    chk("stream_drained", {63'd0, outValid}, 64'd0);
    chk("stream_busy", {63'd0, busy}, 64'd0);

    // Reset with two requests in flight.
    inValid  = 1'b1;
    control  = 3'b000;
    operantA = 32'd5;
    operantB = 32'd1;
    step();
    operantA = 32'd6;
    #1;
    reset_n = 1'b0;
    inValid = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_outValid", {63'd0, outValid}, 64'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst_valid%0d", i), {63'd0, outValid}, 64'd0);
      chk($sformatf("post_rst_busy%0d", i), {63'd0, busy}, 64'd0);
    end
    chk("post_rst_inReady", {63'd0, inReady}, 64'd1);

    // 64-bit, 6-stage: amount field of 0x40 is zero.
    v64_in = 1'b1;
    ctl64  = 3'b000;
    a64    = 64'd1;
    bb64   = 64'h40;
    step();
    v64_in = 1'b0;
    for (int i = 1; i < 6; i++) begin
      chk($sformatf("w64_lat%0d", i), {63'd0, v64_out}, 64'd0);
      step();
    end
    chk("w64_valid", {63'd0, v64_out}, 64'd1);
    chk("w64_result", res64, 64'd1);
    chk("w64_carry", {63'd0, c64}, 64'd0);
    step();
    chk("w64_drained", {63'd0, b64}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
